// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4 memory slave.
package axi_mem_pkg;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 bus between a master and the memory slave.
// Handshake: a beat transfers on a rising clk edge where valid and ready are both 1;
// valid never waits on ready, and payload holds steady while valid is high and ready low.
interface axi_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_mem_ram.sv
// Dual-port RAM: registered read port, byte-enabled write port.
// A same-cycle read and write of one word returns the old contents.
module axi_mem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W/8-1:0]      wr_strb,
  input  logic [DATA_W-1:0]        wr_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
    if (wr_en) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent read/write FSMs, one outstanding burst each, INCR only.
// Optional AXI_MEM_STALL_EN: an LFSR gates rvalid/wready to inject back-pressure.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_ID_WIDTH   = 8,
  parameter int                        MEM_DEPTH      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  axi_mem_slave_if.slave s_axi,
  output rd_state_t   rd_state_dbg,
  output wr_state_t   wr_state_dbg
);
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int IDX_W          = $clog2(MEM_DEPTH);
  localparam int OFF_W          = $clog2(AXI_STRB_WIDTH);

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic stall_gate;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic rvalid_i, wready_i, r_last_beat, r_held;

  logic [AXI_ID_WIDTH-1:0] rd_id, wr_id;
  logic [IDX_W-1:0]        rd_idx, wr_idx, ar_idx, aw_idx;
  logic [7:0]              rd_len, rd_beat, wr_len, wr_beat;
  logic                    wr_over;
  logic [1:0]              bresp_q;

  logic                      ram_rd_en;
  logic [IDX_W-1:0]          ram_rd_idx;
  logic [AXI_DATA_WIDTH-1:0] ram_q;

`ifdef AXI_MEM_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
  assign stall_gate = lfsr[0];
`else
  assign stall_gate = 1'b1;
`endif

  assign ar_idx = IDX_W'((s_axi.araddr - BASE_ADDR) >> OFF_W);
  assign aw_idx = IDX_W'((s_axi.awaddr - BASE_ADDR) >> OFF_W);

  assign ar_hs = s_axi.arvalid && (rd_state == R_IDLE);
  assign r_hs  = rvalid_i && s_axi.rready;
  assign aw_hs = s_axi.awvalid && (wr_state == W_IDLE);
  assign w_hs  = s_axi.wvalid && wready_i;
  assign b_hs  = (wr_state == W_RESP) && s_axi.bready;

  // Once presented, a read beat is held until accepted even if the gate drops.
  assign rvalid_i    = (rd_state == R_DATA) && (stall_gate || r_held);
  assign r_last_beat = (rd_beat == rd_len);
  assign wready_i    = (wr_state == W_DATA) && stall_gate;

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = (rd_state == R_IDLE);
    s_axi.rvalid  = rvalid_i;
    s_axi.rlast   = rvalid_i && r_last_beat;
    s_axi.rdata   = rvalid_i ? ram_q : '0;
    s_axi.rid     = rd_id;
    s_axi.rresp   = RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_id   <= '0;
      rd_idx  <= '0;
      rd_len  <= '0;
      rd_beat <= '0;
      r_held  <= 1'b0;
    end else begin
      r_held <= rvalid_i && !s_axi.rready;
      if (ar_hs) begin
        rd_id   <= s_axi.arid;
        rd_idx  <= ar_idx;
        rd_len  <= s_axi.arlen;
        rd_beat <= '0;
      end else if (r_hs) begin
        rd_idx  <= rd_idx + 1'b1;
        rd_beat <= rd_beat + 1'b1;
      end
    end
  end

  // Prefetch the next word on each accepted beat so bursts stream without bubbles.
  assign ram_rd_en  = ar_hs || (r_hs && !r_last_beat);
  assign ram_rd_idx = ar_hs ? ar_idx : rd_idx + 1'b1;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_state <= W_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_next = W_DATA;
      W_DATA:  if (w_hs && s_axi.wlast) wr_next = W_RESP;
      W_RESP:  if (b_hs) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = (wr_state == W_IDLE);
    s_axi.wready  = wready_i;
    s_axi.bvalid  = (wr_state == W_RESP);
    s_axi.bid     = wr_id;
    s_axi.bresp   = bresp_q;
  end

  // wr_over remembers that the beat counter passed len, so a later 8-bit wrap cannot fake OKAY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_id   <= '0;
      wr_idx  <= '0;
      wr_len  <= '0;
      wr_beat <= '0;
      wr_over <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else if (aw_hs) begin
      wr_id   <= s_axi.awid;
      wr_idx  <= aw_idx;
      wr_len  <= s_axi.awlen;
      wr_beat <= '0;
      wr_over <= 1'b0;
    end else if (w_hs) begin
      wr_idx  <= wr_idx + 1'b1;
      wr_beat <= wr_beat + 1'b1;
      if ((wr_beat == wr_len) && !s_axi.wlast) wr_over <= 1'b1;
      if (s_axi.wlast)
        bresp_q <= ((wr_beat == wr_len) && !wr_over) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axi_mem_ram #(
    .DATA_W (AXI_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .rd_idx  (ram_rd_idx),
    .rd_data (ram_q),
    .wr_en   (w_hs),
    .wr_idx  (wr_idx),
    .wr_strb (s_axi.wstrb),
    .wr_data (s_axi.wdata)
  );

  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave: driver tasks feed a word-array reference model and expected
// queues; a negedge monitor pops and compares every R and B beat the slave presents.
module tb_axi_mem_slave;
  import axi_mem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int IW    = 8;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 1024;
  localparam int EW    = IW + 1 + 2 + DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) bus ();
  rd_state_t rd_dbg;
  wr_state_t wr_dbg;

  axi_mem_slave #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .AXI_ID_WIDTH   (IW),
    .MEM_DEPTH      (DEPTH),
    .BASE_ADDR      ('0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axi        (bus.slave),
    .rd_state_dbg (rd_dbg),
    .wr_state_dbg (wr_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int r_seen  = 0;
  int b_seen  = 0;
  logic [EW-1:0]   exp_q[$];
  logic [IW+1:0]   exp_b_q[$];
  logic [DW-1:0]   model [DEPTH];
  logic [DW-1:0]   wbuf [256];
  logic [SW-1:0]   sbuf [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic [EW-1:0] r_exp;
  logic [IW+1:0] b_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("r_hold_valid", 64'(bus.rvalid), 64'd1);
        check("r_hold_data", 64'(bus.rdata), 64'(prev_data));
      end
      prev_stall = bus.rvalid && !bus.rready;
      prev_data  = bus.rdata;
      if (bus.rvalid && bus.rready) begin
        check("r_expected_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          r_exp = exp_q.pop_front();
          check("r_beat", 64'({bus.rid, bus.rlast, bus.rresp, bus.rdata}), 64'(r_exp));
        end
        r_seen++;
      end
      if (bus.bvalid && bus.bready) begin
        check("b_expected_pending", 64'(exp_b_q.size() != 0), 64'd1);
        if (exp_b_q.size() != 0) begin
          b_exp = exp_b_q.pop_front();
          check("b_resp", 64'({bus.bid, bus.bresp}), 64'(b_exp));
        end
        b_seen++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ar_send(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
    int n;
    n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len;
    bus.arsize = 3'd2; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.arready || n > 50) break;
      n++;
    end
    check("ar_accept", 64'(bus.arready), 64'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id);
    int n;
    n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len;
    bus.awsize = 3'd2; bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.awready || n > 50) break;
      n++;
    end
    check("aw_accept", 64'(bus.awready), 64'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                          input int nbeats, input bit rnd);
    int base, n, target;
    base = int'((addr >> 2) % DEPTH);
    for (int i = 0; i < nbeats; i++)
      model[(base + i) % DEPTH] = merge(model[(base + i) % DEPTH], wbuf[i], sbuf[i]);
    exp_b_q.push_back({id, (nbeats == int'(len) + 1) ? RESP_OKAY : RESP_SLVERR});
    target = b_seen + 1;
    aw_send(addr, len, id);
    for (int i = 0; i < nbeats; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      bus.wdata = wbuf[i]; bus.wstrb = sbuf[i]; bus.wlast = (i == nbeats - 1); bus.wvalid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (bus.wready || n > 50) break;
        n++;
      end
      check("w_accept", 64'(bus.wready), 64'd1);
      @(posedge clk); #1;
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
    end
    n = 0;
    bus.bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (b_seen < target && n < 100) begin
      @(posedge clk); #1;
      n++;
      bus.bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("b_done", 64'(b_seen), 64'(target));
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IW-1:0] id,
                         input bit rnd, input logic [15:0] pat);
    int base, k, target;
    base = int'((addr >> 2) % DEPTH);
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back({id, (i == int'(len)), RESP_OKAY, model[(base + i) % DEPTH]});
    target = r_seen + int'(len) + 1;
    bus.rready = 1'b0;
    ar_send(addr, len, id);
    k = 0;
    bus.rready = rnd ? 1'($urandom_range(0, 1)) : pat[0];
    @(negedge clk);
    check("r_latency", 64'(bus.rvalid), 64'd1);
    while (r_seen < target && k < 300) begin
      @(posedge clk); #1;
      k++;
      bus.rready = rnd ? 1'($urandom_range(0, 1)) : ((k < 16) ? pat[k] : 1'b1);
    end
    check("r_done", 64'(r_seen), 64'(target));
    bus.rready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a;
    logic [7:0]    l;
    int            nb;
    bus.arvalid = 0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.awvalid = 0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
    bus.rready = 0; bus.bready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_rvalid",  64'(bus.rvalid),  64'd0);
    check("rst_rlast",   64'(bus.rlast),   64'd0);
    check("rst_wready",  64'(bus.wready),  64'd0);
    check("rst_bvalid",  64'(bus.bvalid),  64'd0);
    check("rst_rdata",   64'(bus.rdata),   64'd0);
    check("rst_rid",     64'(bus.rid),     64'd0);
    check("rst_bid",     64'(bus.bid),     64'd0);
    check("rst_rresp",   64'(bus.rresp),   64'd0);
    check("rst_bresp",   64'(bus.bresp),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Give every word a known value so any later read has a defined expectation.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(32'(blk * 1024), 8'd255, 8'(blk), 256, 1'b0);
    end

    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
    do_write(32'h10, 8'd3, 8'h5A, 4, 1'b0);
    do_read(32'h10, 8'd3, 8'h3C, 1'b0, 16'hFFFF);

    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'hF;
    do_write(32'h14, 8'd0, 8'h01, 1, 1'b0);
    wbuf[0] = 32'h00001122; sbuf[0] = 4'b0011;
    do_write(32'h14, 8'd0, 8'h02, 1, 1'b0);
    do_read(32'h14, 8'd0, 8'h03, 1'b0, 16'hFFFF);

    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(32'h40, 8'd3, 8'h07, 2, 1'b0);
    do_read(32'h40, 8'd3, 8'h08, 1'b0, 16'hFFFF);

    do_write(32'h80, 8'd1, 8'h09, 3, 1'b0);
    do_read(32'h80, 8'd2, 8'h0A, 1'b0, 16'hFFFF);

    do_read(32'hFFC, 8'd1, 8'h04, 1'b0, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(32'hFF8, 8'd3, 8'h0B, 4, 1'b0);
    do_read(32'hFF8, 8'd3, 8'h0C, 1'b0, 16'hFFFF);

    do_read(32'h10, 8'd3, 8'h06, 1'b0, 16'hFFF9);

    for (int op = 0; op < 40; op++) begin
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      l = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0:       nb = (l == 0) ? 1 : int'(l);
          1:       nb = int'(l) + 2;
          default: nb = int'(l) + 1;
        endcase
        for (int i = 0; i < nb; i++) begin
          wbuf[i] = $urandom;
          sbuf[i] = 4'($urandom_range(0, 15));
        end
        do_write(a, l, 8'($urandom_range(0, 255)), nb, 1'b1);
      end else begin
        do_read(a, l, 8'($urandom_range(0, 255)), 1'b1, 16'hFFFF);
      end
    end

    // Reset in the middle of a stalled read burst.
    bus.rready = 1'b0;
    ar_send(32'h200, 8'd3, 8'h11);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid",  64'(bus.rvalid),  64'd0);
    check("midrst_rlast",   64'(bus.rlast),   64'd0);
    check("midrst_arready", 64'(bus.arready), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(32'h200, 8'd3, 8'h12, 1'b0, 16'hFFFF);

    repeat (3) @(posedge clk);
    check("queues_drained", 64'(exp_q.size() + exp_b_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
